uart_rx_byte: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/baud_tick_gen.sv | 35 +++
 rtl/uart_rx_byte.sv | 140 ++++++++++++++
 tb/tb_uart_rx_byte.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and
// the baud divisor calculation used by both the receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int OVERSAMPLE_C = 16;
  localparam int SAMPLE_LO    = 7;
  localparam int SAMPLE_MID   = 8;
  localparam int SAMPLE_HI    = 9;

  // Clock cycles per oversampling tick, truncated.
  function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-cycle tick at BAUD_RATE*OVERSAMPLE.
// Shared by the UART receiver and transmitter.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  generate
    if (DIV < 1) begin : g_div_chk
      $error("baud_tick_gen: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
  endgenerate

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)            cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote per bit,
// start-glitch rejection, framing-error detection and break handling.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       framing_error,
  output logic       busy
);

  generate
    if (OVERSAMPLE != OVERSAMPLE_C) begin : g_os_chk
      $error("uart_rx_byte: OVERSAMPLE must be 16");
    end
  endgenerate

  logic rx_m, rx_s;
  logic [1:0] settle;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      settle <= 2'b00;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      settle <= {settle[0], 1'b1};
    end
  end

  logic tick;

  baud_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  rx_state_t  state;
  logic [3:0] sc, sc_nxt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  logic       smp_lo, smp_mid, line_high;
  logic       decide, maj;

  // Sample points are named by the count sc reaches on that tick, so the
  // entry tick of a state is position 0 and the 3 votes straddle mid-bit.
  assign sc_nxt = sc + 4'd1;
  assign decide = tick && (sc_nxt == 4'(SAMPLE_HI));
  assign maj    = (smp_lo & smp_mid) | (smp_lo & rx_s) | (smp_mid & rx_s);
  assign busy   = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      sc            <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      smp_lo        <= 1'b0;
      smp_mid       <= 1'b0;
      line_high     <= 1'b0;
      rx_data       <= 8'h00;
      rx_ready      <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_ready      <= 1'b0;
      framing_error <= 1'b0;
      if (tick) begin
        sc <= sc_nxt;
        // A start needs the line seen high first; skips the synchronizer's
        // reset value so a reset mid-frame cannot trigger a false start.
        if (settle[1]) line_high <= rx_s;
        if (sc_nxt == 4'(SAMPLE_LO))  smp_lo  <= rx_s;
        if (sc_nxt == 4'(SAMPLE_MID)) smp_mid <= rx_s;
        case (state)
          IDLE: begin
            if (!rx_s && line_high) begin
              state <= START;
              sc    <= '0;
            end
          end
          START: begin
            if (decide && maj) begin
              state <= IDLE;
              sc    <= '0;
            end else if (sc == 4'd15) begin
              state   <= DATA;
              sc      <= '0;
              bit_idx <= '0;
            end
          end
          DATA: begin
            if (decide) shift_reg <= {maj, shift_reg[7:1]};
            if (sc == 4'd15) begin
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                state <= STOP;
                sc    <= '0;
              end
            end
          end
          STOP: begin
            if (decide) begin
              sc <= '0;
              if (maj) begin
                rx_data  <= shift_reg;
                rx_ready <= 1'b1;
                state    <= IDLE;
              end else begin
                framing_error <= 1'b1;
                state         <= BREAK;
              end
            end
          end
          BREAK: begin
            if (rx_s) begin
              state <= IDLE;
              sc    <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomised and directed bench for uart_rx_byte: a line-history decoder model
// predicts every rx_ready/framing_error pulse and the held rx_data value.
module tb_uart_rx_byte;

  localparam int CLK_FREQ = 14_745_600;
  localparam int BAUD     = 115200;
  localparam int D        = CLK_FREQ / (BAUD * 16);   // 8 cycles per tick
  localparam int BIT      = 16 * D;
  localparam int LAT_LO   = 153 * D + 1;
  localparam int LAT_HI   = 153 * D + D + 4;
  localparam int HN       = 131072;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_ready, framing_error, busy;

  uart_rx_byte #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD),
    .OVERSAMPLE(16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: every line level is logged; a frame is decoded by majority of the
  // levels one tick either side of each ideal bit centre.
  bit         hist [HN];
  int         edges[$];
  int         pulse_t[$];
  int         n_ferr = 0;
  logic [7:0] model_data = 8'h00;
  bit         prev_pulse = 1'b0;

  function automatic bit lvl(input int t);
    return (t >= 0 && t < HN) ? hist[t] : 1'b1;
  endfunction

  function automatic bit bitval(input int te, input int k);
    int c;
    bit a, b, e;
    c = te + 1 + k * BIT + BIT / 2;
    a = lvl(c - D);
    b = lvl(c);
    e = lvl(c + D);
    return (a & b) | (a & e) | (b & e);
  endfunction

  int         cte, clat;
  bit         cstop;
  logic [7:0] cexp;

  initial begin
    forever begin
      @(posedge clock);
      #3;
      if (cyc < HN) hist[cyc] = rx;
      if (reset) begin
        model_data = 8'h00;
        prev_pulse = 1'b0;
        chk(!busy && !rx_ready && !framing_error, "reset_outputs",
            32'({busy, rx_ready, framing_error}), 32'h0);
      end else begin
        if (rx_ready || framing_error) begin
          if (framing_error) n_ferr++;
          chk(!(rx_ready && framing_error), "pulse_exclusive", 32'({rx_ready, framing_error}), 32'h1);
          chk(!prev_pulse, "pulse_consecutive", 32'(prev_pulse), 32'h0);
          if (edges.size() == 0) begin
            chk(1'b0, "unexpected_pulse", 32'({rx_ready, framing_error}), 32'h0);
          end else begin
            cte  = edges.pop_front();
            clat = cyc - cte;
            chk(clat >= LAT_LO && clat <= LAT_HI, "latency", 32'(clat), 32'(LAT_LO));
            cstop = bitval(cte, 9);
            chk(framing_error == !cstop, "pulse_kind", 32'(framing_error), 32'(!cstop));
            if (cstop) begin
              for (int k = 0; k < 8; k++) cexp[k] = bitval(cte, k + 1);
              model_data = cexp;
              pulse_t.push_back(cyc);
            end
          end
        end else if (edges.size() > 0 && (cyc - edges[0]) > LAT_HI) begin
          chk(1'b0, "missing_pulse", 32'(cyc - edges[0]), 32'(LAT_HI));
          void'(edges.pop_front());
        end
        prev_pulse = rx_ready || framing_error;
      end
      chk(rx_data == model_data, "rx_data_hold", 32'(rx_data), 32'(model_data));
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    hold(n);
  endtask

  // One bit time; optional one-tick opposite spike centred mid-bit, or a
  // 2-cycle reset pulse a quarter of the way into the bit.
  task automatic drive_bit(input bit v, input bit spike, input bit do_rst);
    rx = v;
    if (do_rst) begin
      hold(BIT / 4);
      reset = 1'b1;
      hold(2);
      reset = 1'b0;
      hold(BIT - BIT / 4 - 2);
    end else if (spike) begin
      hold(8 * D - D / 2);
      rx = ~v;
      hold(D);
      rx = v;
      hold(BIT - 8 * D - D / 2);
    end else begin
      hold(BIT);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop_lvl, input int stop_len,
                      input bit spike, input int rst_bit, input bit expect_frame);
    if (expect_frame) edges.push_back(cyc);
    drive_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], spike, rst_bit == i);
    rx = stop_lvl;
    hold(stop_len);
    rx = 1'b1;
  endtask

  initial begin
    int         t55, lat, gap, w, slen;
    bit         saw_busy, sp, bad;
    logic [7:0] b;

    reset = 1'b1;
    rx    = 1'b1;
    hold(4);
    reset = 1'b0;
    idle(3 * BIT);

    // 0x55, latency pinned by hand: 153 ticks * 8 = 1224 cycles plus sync/tick phase
    t55 = cyc;
    send(8'h55, 1'b1, BIT, 1'b0, -1, 1'b1);
    idle(BIT);
    chk(rx_data == 8'h55, "lit_55", 32'(rx_data), 32'h55);
    chk(pulse_t.size() == 1, "count_55", 32'(pulse_t.size()), 32'd1);
    lat = (pulse_t.size() > 0) ? pulse_t[0] - t55 : 0;
    chk(lat >= 1225 && lat <= 1236, "lit_latency_55", 32'(lat), 32'd1225);

    // Back-to-back 0xA3, 0x0F: pulses one frame (1280 cycles) apart
    send(8'hA3, 1'b1, BIT, 1'b0, -1, 1'b1);
    chk(rx_data == 8'hA3, "lit_A3", 32'(rx_data), 32'hA3);
    send(8'h0F, 1'b1, BIT, 1'b0, -1, 1'b1);
    idle(BIT);
    chk(rx_data == 8'h0F, "lit_0F", 32'(rx_data), 32'h0F);
    chk(pulse_t.size() == 3, "count_b2b", 32'(pulse_t.size()), 32'd3);
    lat = (pulse_t.size() == 3) ? pulse_t[2] - pulse_t[1] : 0;
    chk(lat >= 1272 && lat <= 1288, "lit_b2b_spacing", 32'(lat), 32'd1280);

    // Short low glitch on an idle line
    rx = 1'b0;
    saw_busy = 1'b0;
    repeat (BIT / 3) begin
      @(negedge clock);
      saw_busy |= busy;
    end
    rx = 1'b1;
    w = 0;
    while (busy && w < BIT) begin
      @(negedge clock);
      w++;
    end
    chk(saw_busy, "glitch_busy_seen", 32'(saw_busy), 32'h1);
    chk(!busy, "glitch_busy_clears", 32'(busy), 32'h0);
    idle(BIT);
    chk(pulse_t.size() == 3 && n_ferr == 0, "glitch_no_pulse", 32'(pulse_t.size()), 32'd3);

    // 0xFF with stop low and line held low three bit times
    send(8'hFF, 1'b0, 3 * BIT, 1'b0, -1, 1'b1);
    chk(busy, "break_busy", 32'(busy), 32'h1);
    idle(BIT);
    chk(!busy, "break_exit", 32'(busy), 32'h0);
    chk(n_ferr == 1, "lit_ferr_count", 32'(n_ferr), 32'd1);
    chk(rx_data == 8'h0F, "lit_ferr_keeps", 32'(rx_data), 32'h0F);
    send(8'h81, 1'b1, BIT, 1'b0, -1, 1'b1);
    idle(BIT);
    chk(rx_data == 8'h81, "lit_81", 32'(rx_data), 32'h81);

    // Reset during data bit 4 of 0xC6, then 0x3C
    send(8'hC6, 1'b1, BIT, 1'b0, 4, 1'b0);
    idle(2 * BIT);
    chk(rx_data == 8'h00 && pulse_t.size() == 4, "lit_reset_drop", 32'(rx_data), 32'h0);
    send(8'h3C, 1'b1, BIT, 1'b0, -1, 1'b1);
    idle(BIT);
    chk(rx_data == 8'h3C, "lit_3C", 32'(rx_data), 32'h3C);

    // Mid-bit spikes inside every data bit of 0x96
    send(8'h96, 1'b1, BIT, 1'b1, -1, 1'b1);
    idle(BIT);
    chk(rx_data == 8'h96, "lit_96", 32'(rx_data), 32'h96);

    // Random frames: random data, spikes, occasional bad stop, random gaps
    for (int n = 0; n < 24; n++) begin
      b   = 8'($urandom);
      sp  = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 7) == 0);
      if (bad) begin
        slen = BIT * (1 + int'($urandom_range(0, 2)));
        send(b, 1'b0, slen, sp, -1, 1'b1);
        idle(BIT);
      end else begin
        send(b, 1'b1, BIT, sp, -1, 1'b1);
        gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 2 * BIT));
        idle(gap);
      end
    end

    idle(2 * BIT);
    chk(edges.size() == 0, "all_frames_done", 32'(edges.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
